hp35_rom_sequencer: RTL and testbench

//  Word-time sequencer for the HP-35 ROM bank.
//  - Runs the 56-bit-time word cycle and captures the serial ROM address from the control & timing chip.
//  - Drives address and one-hot chip select to NUM_ROMS ROMs.
//  - Serialises the selected ROM's 10-bit instruction onto is_out inside a sync window.
//  - Sits between the control & timing logic and the ROM control/decode netlists; it arbitrates which ROM owns the bus.

---
 rtl/hp35_rom_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hp35_rom_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hp35_rom_sequencer.sv
// ---------------------------------------------------------------------------
// hp35_rom_sequencer
//
// Word-time sequencer for the HP-35 ROM bank. Counts the 56 bit-times of a
// word cycle, captures the serial ROM address sent by the control & timing
// chip, drives the held address and a one-hot chip select to the ROMs, and
// serialises the selected ROM's 10-bit instruction onto is_out during the
// sync window. ROM-select instructions seen on the bus are queued and take
// effect at the next address load, so the current word always finishes on
// the ROM that started it.
//
// Ports:
//   clk        in   bit-time clock, all state on posedge
//   rst_n      in   async active-low reset
//   run        in   1 = advance, 0 = freeze all state (sync/is_out/word_start low)
//   ia         in   serial address bit, LSB first, bt ADDR_START..ADDR_START+7
//   rom_data   in   [9:0] instruction from selected ROM, valid by bt SYNC_START-1
//   rom_addr   out  [7:0] held word address for all ROMs
//   rom_sel    out  [NUM_ROMS-1:0] one-hot ROM enable
//   sync       out  high during the 10-bit instruction window
//   is_out     out  serial instruction, LSB first, 0 outside the window
//   bt         out  [5:0] current bit-time 0..WORD_BITS-1
//   word_start out  high when bt==0 and running
//
// Configuration macro:
//   HP35_SEL_DELAY_EN  when defined, a queued ROM select waits one extra full
//                      word before it is applied; a newer select replaces it
//                      and restarts the wait.
// ---------------------------------------------------------------------------
module hp35_rom_sequencer #(
    parameter int WORD_BITS  = 56,
    parameter int NUM_ROMS   = 3,
    parameter int ADDR_START = 19,
    parameter int SYNC_START = 45
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                ia,
    input  logic [9:0]          rom_data,
    output logic [7:0]          rom_addr,
    output logic [NUM_ROMS-1:0] rom_sel,
    output logic                sync,
    output logic                is_out,
    output logic [5:0]          bt,
    output logic                word_start
);

    // Bit-time landmarks, sized to the counter so every compare is 6 bits.
    localparam logic [5:0] LP_BT_LAST    = 6'(WORD_BITS - 1);
    localparam logic [5:0] LP_ADDR_FIRST = 6'(ADDR_START);
    localparam logic [5:0] LP_ADDR_LAST  = 6'(ADDR_START + 7);
    localparam logic [5:0] LP_ADDR_LOAD  = 6'(ADDR_START + 8);
    localparam logic [5:0] LP_CAPTURE    = 6'(SYNC_START - 1);
    localparam logic [5:0] LP_SYNC_FIRST = 6'(SYNC_START);
    localparam logic [5:0] LP_SYNC_LAST  = 6'(SYNC_START + 9);
    localparam logic [3:0] LP_NUM_ROMS   = 4'(NUM_ROMS);
    localparam logic [NUM_ROMS-1:0] LP_SEL_ROM0 = {{(NUM_ROMS-1){1'b0}}, 1'b1};

    // Queued-select tracker. SEL_WAIT is only entered in the delayed build.
    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_WAIT  = 2'd1,
        SEL_ARMED = 2'd2
    } sel_state_t;

    logic [5:0]          r_bt;
    logic [7:0]          r_addr_sr;
    logic [7:0]          r_rom_addr;
    logic [NUM_ROMS-1:0] r_rom_sel;
    logic [9:0]          r_inst_sr;
    logic [2:0]          r_pend_n;
    sel_state_t          r_sel_state;

    sel_state_t          w_sel_state_nxt;
    logic                w_sel_apply;
    logic                w_addr_shift;
    logic                w_addr_load;
    logic                w_capture;
    logic                w_sync;
    logic                w_sel_take;

    // Every action is qualified by run so that a frozen sequencer resumes
    // exactly where it stopped.
    assign w_addr_shift = run && (r_bt >= LP_ADDR_FIRST) && (r_bt <= LP_ADDR_LAST);
    assign w_addr_load  = run && (r_bt == LP_ADDR_LOAD);
    assign w_capture    = run && (r_bt == LP_CAPTURE);
    assign w_sync       = run && (r_bt >= LP_SYNC_FIRST) && (r_bt <= LP_SYNC_LAST);

    // Select instruction: low 7 bits 0010000, target ROM in [9:7]; targets
    // beyond the populated ROMs are dropped.
    assign w_sel_take = w_capture && (rom_data[6:0] == 7'b0010000)
                        && ({1'b0, rom_data[9:7]} < LP_NUM_ROMS);

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_sel_state_nxt = r_sel_state;
        w_sel_apply     = 1'b0;
        if (w_sel_take) begin
`ifdef HP35_SEL_DELAY_EN
            w_sel_state_nxt = SEL_WAIT;
`else
            w_sel_state_nxt = SEL_ARMED;
`endif
        end else if (w_addr_load) begin
            case (r_sel_state)
                SEL_WAIT:  w_sel_state_nxt = SEL_ARMED;
                SEL_ARMED: begin
                    w_sel_state_nxt = SEL_IDLE;
                    w_sel_apply     = 1'b1;
                end
                default:   w_sel_state_nxt = r_sel_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_state <= SEL_IDLE;
        end else begin
            r_sel_state <= w_sel_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bt       <= '0;
            r_addr_sr  <= '0;
            r_rom_addr <= '0;
            r_rom_sel  <= LP_SEL_ROM0;
            r_inst_sr  <= '0;
            r_pend_n   <= '0;
        end else begin
            if (run) begin
                r_bt <= (r_bt == LP_BT_LAST) ? 6'd0 : r_bt + 6'd1;
            end

            if (w_addr_shift) begin
                r_addr_sr <= {ia, r_addr_sr[7:1]};
            end

            if (w_addr_load) begin
                r_rom_addr <= r_addr_sr;
            end

            // Capture sits one bit-time before the window, so the two
            // branches never compete.
            if (w_capture) begin
                r_inst_sr <= rom_data;
            end else if (w_sync) begin
                r_inst_sr <= {1'b0, r_inst_sr[9:1]};
            end

            if (w_sel_take) begin
                r_pend_n <= rom_data[9:7];
            end

            if (w_sel_apply) begin
                r_rom_sel <= LP_SEL_ROM0 << r_pend_n;
            end
        end
    end

    assign bt         = r_bt;
    assign rom_addr   = r_rom_addr;
    assign rom_sel    = r_rom_sel;
    assign sync       = w_sync;
    assign is_out     = w_sync & r_inst_sr[0];
    // Gated by rst_n so the pulse is low while reset holds the counter at 0.
    assign word_start = run & rst_n & (r_bt == 6'd0);

endmodule

// File: tb/tb_hp35_rom_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hp35_rom_sequencer
//
// Directed bench for hp35_rom_sequencer. A table of whole-word vectors
// (serial address, ROM instruction, expected chip select) is replayed one
// word per entry; hand-written sequences then cover the run freeze inside
// the sync window and a reset landing in the middle of the window.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hp35_rom_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       ia;
    logic [9:0] rom_data;
    logic [7:0] rom_addr;
    logic [2:0] rom_sel;
    logic       sync;
    logic       is_out;
    logic [5:0] bt;
    logic       word_start;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] last_addr;

    hp35_rom_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .ia         (ia),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .rom_sel    (rom_sel),
        .sync       (sync),
        .is_out     (is_out),
        .bt         (bt),
        .word_start (word_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;      // serial address sent this word
        logic [9:0] data;      // instruction presented this word
        logic [2:0] sel_dflt;  // rom_sel expected at bt28, immediate select
        logic [2:0] sel_dly;   // rom_sel expected at bt28, delayed select
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive ia for the current bit-time k and move to the next falling edge.
    task automatic tick(input int k, input logic [7:0] a);
        ia = (k >= 19 && k <= 26) ? a[k-19] : 1'b0;
        @(negedge clk);
    endtask

    // Run one full word starting at bt==0 and check everything observed.
    task automatic run_word(input vec_t v);
        int         bt_err = 0;
        int         ws_cnt = 0;
        int         ws_bad = 0;
        int         nsync  = 0;
        int         leak   = 0;
        logic [9:0] bits   = '0;
        logic [2:0] exp_sel;
`ifdef HP35_SEL_DELAY_EN
        exp_sel = v.sel_dly;
`else
        exp_sel = v.sel_dflt;
`endif
        rom_data = v.data;
        for (int k = 0; k < 56; k++) begin
            if (bt !== 6'(k)) bt_err++;
            if (word_start === 1'b1) begin
                ws_cnt++;
                if (k != 0) ws_bad++;
            end
            if (sync === 1'b1) begin
                if (nsync < 10) bits[nsync] = is_out;
                nsync++;
                if (k < 45 || k > 54) leak++;
            end else if (is_out !== 1'b0) begin
                leak++;
            end
            if (k == 27) check("addr_hold_prev", 64'(rom_addr), 64'(last_addr));
            if (k == 28) begin
                check("addr_load", 64'(rom_addr), 64'(v.addr));
                check("rom_sel", 64'(rom_sel), 64'(exp_sel));
            end
            if (k == 55) check("addr_hold_end", 64'(rom_addr), 64'(v.addr));
            tick(k, v.addr);
        end
        last_addr = v.addr;
        check("bt_track", 64'(bt_err), 64'd0);
        check("word_start_cnt", 64'(ws_cnt), 64'd1);
        check("word_start_pos", 64'(ws_bad), 64'd0);
        check("sync_len", 64'(nsync), 64'd10);
        check("is_leak", 64'(leak), 64'd0);
        check("is_bits", 64'(bits), 64'(v.data));
    endtask

    vec_t vecs[8];
    vec_t post[2];

    initial begin
        int         n;
        int         hold_err;
        logic [9:0] bits;

        //          addr    data     sel_dflt sel_dly
        vecs[0] = '{8'hA5, 10'h2AB, 3'b001, 3'b001};  // plain instruction
        vecs[1] = '{8'h3C, 10'h110, 3'b001, 3'b001};  // select ROM2
        vecs[2] = '{8'hFF, 10'h190, 3'b100, 3'b001};  // select ROM3: ignored
        vecs[3] = '{8'h00, 10'h2AB, 3'b100, 3'b100};
        vecs[4] = '{8'h5A, 10'h090, 3'b100, 3'b100};  // select ROM1
        vecs[5] = '{8'h81, 10'h010, 3'b010, 3'b100};  // select ROM0 (replaces when delayed)
        vecs[6] = '{8'h7E, 10'h3FF, 3'b001, 3'b100};
        vecs[7] = '{8'hC3, 10'h110, 3'b001, 3'b001};  // select ROM2 again
        post[0] = '{8'h12, 10'h000, 3'b001, 3'b001};
        post[1] = '{8'h34, 10'h155, 3'b001, 3'b001};

        rst_n     = 1'b0;
        run       = 1'b1;
        ia        = 1'b0;
        rom_data  = '0;
        last_addr = 8'h00;

        // Reset state with run held high.
        #23;
        check("rst_bt", 64'(bt), 64'd0);
        check("rst_sel", 64'(rom_sel), 64'h1);
        check("rst_addr", 64'(rom_addr), 64'h00);
        check("rst_sync", 64'(sync), 64'd0);
        check("rst_is", 64'(is_out), 64'd0);
        check("rst_ws", 64'(word_start), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) run_word(vecs[i]);

        // Freeze at bt48 for 5 clocks inside the window, then resume.
        rom_data = 10'h2AB;
        bits     = '0;
        n        = 0;
        for (int k = 0; k < 48; k++) begin
            if (sync === 1'b1) begin
                if (n < 10) bits[n] = is_out;
                n++;
            end
            tick(k, 8'h96);
        end
        check("pause_at_bt", 64'(bt), 64'd48);
        run = 1'b0;
        #1;
        check("pause_sync", 64'(sync), 64'd0);
        check("pause_is", 64'(is_out), 64'd0);
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bt !== 6'd48 || sync !== 1'b0 || is_out !== 1'b0 || word_start !== 1'b0)
                hold_err++;
        end
        check("pause_hold", 64'(hold_err), 64'd0);
        run = 1'b1;
        #1;
        for (int k = 48; k < 56; k++) begin
            if (sync === 1'b1) begin
                if (n < 10) bits[n] = is_out;
                n++;
            end
            tick(k, 8'h96);
        end
        check("pause_bits", 64'(bits), 64'h2AB);
        check("pause_count", 64'(n), 64'd10);
        check("pause_wrap", 64'(bt), 64'd0);
        check("pause_addr", 64'(rom_addr), 64'h96);

        // Reset at bt50 inside the window; the select captured at bt44 must
        // be discarded as well.
        rom_data = 10'h090;
        for (int k = 0; k < 50; k++) tick(k, 8'h69);
        check("mid_pre_sync", 64'(sync), 64'd1);
        check("mid_pre_is", 64'(is_out), 64'd0);
        check("mid_pre_sel", 64'(rom_sel), 64'h4);
        check("mid_pre_addr", 64'(rom_addr), 64'h69);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sync", 64'(sync), 64'd0);
        check("mid_rst_is", 64'(is_out), 64'd0);
        check("mid_rst_bt", 64'(bt), 64'd0);
        check("mid_rst_ws", 64'(word_start), 64'd0);
        check("mid_rst_sel", 64'(rom_sel), 64'h1);
        check("mid_rst_addr", 64'(rom_addr), 64'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        last_addr = 8'h00;
        #1;
        for (int i = 0; i < 2; i++) run_word(post[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
